// File: rtl/order_pkg.sv
// rtl/order_pkg.sv - shared frame layout constants and parser state encoding
package order_pkg;

  // Formatted frame layout: {seq[31:0], order[63:0], reserved[31:0]}
  localparam int FRAME_W = 128;
  localparam int ORDER_W = 64;
  localparam int SEQ_W   = 32;

  localparam int SEQ_HI = 127;
  localparam int SEQ_LO = 96;
  localparam int ORD_HI = 95;
  localparam int ORD_LO = 32;
  localparam int RSV_HI = 31;
  localparam int RSV_LO = 0;

  // Width of one stored entry: {seq, order}
  localparam int ENTRY_W = SEQ_W + ORDER_W;

  // Sequence tracker state
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } parser_state_t;

endpackage

// File: rtl/order_sync_fifo.sv
// rtl/order_sync_fifo.sv - synchronous FIFO with full/empty flags and simultaneous push/pop
module order_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A push into a full FIFO is still taken when the head leaves in the same cycle
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/order_frame_parser.sv
// rtl/order_frame_parser.sv - validates formatted order frames and queues {seq, order} downstream
import order_pkg::*;

module order_frame_parser #(
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 16,
  parameter bit LOCK_ON_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [127:0]       formatted_order,
  input  logic               formatted_valid,
  output logic [63:0]        order_out,
  output logic [31:0]        order_seq_out,
  output logic               order_valid,
  input  logic               order_ready,
  output logic               seq_locked,
  output logic [CNT_W-1:0]   gap_count,
  output logic [CNT_W-1:0]   dup_count,
  output logic [CNT_W-1:0]   bad_hdr_count,
  output logic [CNT_W-1:0]   overflow_count,
  output logic               seq_error
);

  localparam parser_state_t RESET_STATE = LOCK_ON_FIRST ? HUNT : LOCKED;
  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage register
  logic               stg_valid;
  logic [FRAME_W-1:0] stg_frame;
  logic [SEQ_W-1:0]   stg_seq;
  logic [ORDER_W-1:0] stg_order;
  logic [31:0]        stg_rsv;

  // Sequence tracker
  parser_state_t      state;
  parser_state_t      state_next;
  logic [SEQ_W-1:0]   expected_seq;
  logic [SEQ_W-1:0]   expected_next;
  logic [SEQ_W-1:0]   seq_diff;

  // Classification of the staged frame
  logic               bad_hdr;
  logic               is_gap;
  logic               is_dup;
  logic               accept;
  logic               overflow;

  // FIFO interface
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  assign stg_seq   = stg_frame[SEQ_HI:SEQ_LO];
  assign stg_order = stg_frame[ORD_HI:ORD_LO];
  assign stg_rsv   = stg_frame[RSV_HI:RSV_LO];

  // Stage 1: capture every qualified frame, there is no way to stall the formatter
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_valid <= 1'b0;
      stg_frame <= '0;
    end else begin
      stg_valid <= formatted_valid;
      if (formatted_valid) stg_frame <= formatted_order;
    end
  end

  // Tracker state register: state and the sequence number expected next
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RESET_STATE;
      expected_seq <= '0;
    end else begin
      state        <= state_next;
      expected_seq <= expected_next;
    end
  end

  // Next-state and classification: header check first, then lock, then sequence compare
  always_comb begin
    state_next    = state;
    expected_next = expected_seq;
    bad_hdr       = 1'b0;
    is_gap        = 1'b0;
    is_dup        = 1'b0;
    accept        = 1'b0;
    seq_diff      = stg_seq - expected_seq;
    if (stg_valid) begin
      if (stg_rsv != '0) begin
        bad_hdr = 1'b1;
      end else if (state == HUNT) begin
        accept        = 1'b1;
        state_next    = LOCKED;
        expected_next = stg_seq + SEQ_ONE;
      end else if (seq_diff == '0) begin
        accept        = 1'b1;
        expected_next = expected_seq + SEQ_ONE;
      end else if (!seq_diff[SEQ_W-1]) begin
        // Forward jump: keep the frame and resynchronise on it
        accept        = 1'b1;
        is_gap        = 1'b1;
        expected_next = stg_seq + SEQ_ONE;
      end else begin
        // Behind the expected sequence (modular): stale or duplicate
        is_dup = 1'b1;
      end
    end
  end

  // Tracker outputs
  always_comb begin
    seq_locked = (state == LOCKED);
  end

  // Sequence tracking advances regardless; storage may still refuse the frame
  assign fifo_pop = order_valid && order_ready;
  assign overflow = accept && fifo_full && !fifo_pop;

  order_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data ({stg_seq, stg_order}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is zeroed while empty so the outputs read 0 out of reset
  assign order_valid   = !fifo_empty;
  assign order_out     = order_valid ? fifo_head[ORDER_W-1:0] : '0;
  assign order_seq_out = order_valid ? fifo_head[ENTRY_W-1:ORDER_W] : '0;

  // Error pulse lands in the same cycle the classified frame would appear at the head
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_error <= 1'b0;
    end else begin
      seq_error <= bad_hdr || is_gap || is_dup;
    end
  end

  // Saturating fault counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_count      <= '0;
      dup_count      <= '0;
      bad_hdr_count  <= '0;
      overflow_count <= '0;
    end else begin
      if (is_gap   && gap_count      != CNT_MAX) gap_count      <= gap_count + CNT_ONE;
      if (is_dup   && dup_count      != CNT_MAX) dup_count      <= dup_count + CNT_ONE;
      if (bad_hdr  && bad_hdr_count  != CNT_MAX) bad_hdr_count  <= bad_hdr_count + CNT_ONE;
      if (overflow && overflow_count != CNT_MAX) overflow_count <= overflow_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_order_frame_parser.sv
// tb/tb_order_frame_parser.sv - directed self-checking bench for order_frame_parser
module tb_order_frame_parser;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] formatted_order;
  logic         formatted_valid;
  logic [63:0]  order_out;
  logic [31:0]  order_seq_out;
  logic         order_valid;
  logic         order_ready;
  logic         seq_locked;
  logic [15:0]  gap_count;
  logic [15:0]  dup_count;
  logic [15:0]  bad_hdr_count;
  logic [15:0]  overflow_count;
  logic         seq_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Observed transfers and error pulses, appended by the monitor only
  logic [95:0] got[$];
  int          xfer_cyc[$];
  int          err_pulses = 0;
  logic [31:0] err_seq = '0;

  always #5 clk = ~clk;

  order_frame_parser #(
    .FIFO_DEPTH    (4),
    .CNT_W         (16),
    .LOCK_ON_FIRST (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .formatted_order (formatted_order),
    .formatted_valid (formatted_valid),
    .order_out       (order_out),
    .order_seq_out   (order_seq_out),
    .order_valid     (order_valid),
    .order_ready     (order_ready),
    .seq_locked      (seq_locked),
    .gap_count       (gap_count),
    .dup_count       (dup_count),
    .bad_hdr_count   (bad_hdr_count),
    .overflow_count  (overflow_count),
    .seq_error       (seq_error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sample on the falling edge: a transfer seen here completes on the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      if (order_valid && order_ready) begin
        got.push_back({order_seq_out, order_out});
        xfer_cyc.push_back(cyc);
      end
      if (seq_error) begin
        err_pulses = err_pulses + 1;
        err_seq = order_seq_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [63:0] o, input logic [31:0] r);
    formatted_order = {s, o, r};
    formatted_valid = 1'b1;
    tick();
    formatted_valid = 1'b0;
    formatted_order = '0;
  endtask

  task automatic do_reset();
    formatted_valid = 1'b0;
    formatted_order = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (order_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0h want 0", order_valid); end
    vectors++; if (order_out !== 64'h0) begin miscompares++; $display("FAIL reset_order: got %0h want 0", order_out); end
    vectors++; if (seq_locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0h want 0", seq_locked); end
    vectors++; if (seq_error !== 1'b0) begin miscompares++; $display("FAIL reset_seq_error: got %0h want 0", seq_error); end
    vectors++; if ({gap_count, dup_count, bad_hdr_count, overflow_count} !== 64'h0) begin
      miscompares++; $display("FAIL reset_counters: got %0h want 0", {gap_count, dup_count, bad_hdr_count, overflow_count});
    end
  endtask

  task automatic test_in_order();
    int base, ebase, c0;
    do_reset();
    order_ready = 1'b1;
    base = got.size();
    ebase = err_pulses;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(i, 64'h1000 + i, 32'h0);
    repeat (5) tick();
    vectors++; if (got.size() - base !== 8) begin miscompares++; $display("FAIL inorder_count: got %0d want 8", got.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < got.size()) begin
        vectors++;
        if (got[base + i] !== {i[31:0], 64'h1000 + i}) begin
          miscompares++; $display("FAIL inorder_entry%0d: got %0h want %0h", i, got[base + i], {i[31:0], 64'h1000 + i});
        end
      end
    end
    if (got.size() - base >= 8) begin
      vectors++; if (xfer_cyc[base] - c0 !== 2) begin miscompares++; $display("FAIL inorder_latency: got %0d want 2", xfer_cyc[base] - c0); end
      vectors++; if (xfer_cyc[base + 7] - xfer_cyc[base] !== 7) begin
        miscompares++; $display("FAIL inorder_bubbles: got span %0d want 7", xfer_cyc[base + 7] - xfer_cyc[base]);
      end
    end
    vectors++; if (seq_locked !== 1'b1) begin miscompares++; $display("FAIL inorder_locked: got %0h want 1", seq_locked); end
    vectors++; if ({gap_count, dup_count, bad_hdr_count, overflow_count} !== 64'h0) begin
      miscompares++; $display("FAIL inorder_counters: got %0h want 0", {gap_count, dup_count, bad_hdr_count, overflow_count});
    end
    vectors++; if (err_pulses - ebase !== 0) begin miscompares++; $display("FAIL inorder_errors: got %0d want 0", err_pulses - ebase); end
  endtask

  task automatic test_gap();
    int base, ebase;
    logic [31:0] seqs [5];
    seqs = '{32'd5, 32'd6, 32'd9, 32'd10, 32'd11};
    do_reset();
    order_ready = 1'b1;
    base = got.size();
    ebase = err_pulses;
    for (int i = 0; i < 4; i++) send(seqs[i], 64'hA000 + seqs[i], 32'h0);
    repeat (5) tick();
    vectors++; if (gap_count !== 16'd1) begin miscompares++; $display("FAIL gap_count: got %0d want 1", gap_count); end
    vectors++; if (err_pulses - ebase !== 1) begin miscompares++; $display("FAIL gap_pulses: got %0d want 1", err_pulses - ebase); end
    vectors++; if (err_seq !== 32'd9) begin miscompares++; $display("FAIL gap_pulse_seq: got %0d want 9", err_seq); end
    // Expected sequence is now 11: sending it must not count another gap
    send(32'd11, 64'hA000 + 64'd11, 32'h0);
    repeat (4) tick();
    vectors++; if (gap_count !== 16'd1) begin miscompares++; $display("FAIL gap_resync: got %0d want 1", gap_count); end
    vectors++; if (got.size() - base !== 5) begin miscompares++; $display("FAIL gap_delivered: got %0d want 5", got.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (base + i < got.size()) begin
        vectors++;
        if (got[base + i][95:64] !== seqs[i]) begin
          miscompares++; $display("FAIL gap_seq%0d: got %0d want %0d", i, got[base + i][95:64], seqs[i]);
        end
      end
    end
  endtask

  task automatic test_dup();
    int base, ebase;
    logic [31:0] in_seqs [5];
    logic [31:0] out_seqs [3];
    in_seqs = '{32'd20, 32'd21, 32'd21, 32'd19, 32'd22};
    out_seqs = '{32'd20, 32'd21, 32'd22};
    do_reset();
    order_ready = 1'b1;
    base = got.size();
    ebase = err_pulses;
    for (int i = 0; i < 5; i++) send(in_seqs[i], 64'hB000 + i, 32'h0);
    repeat (5) tick();
    vectors++; if (dup_count !== 16'd2) begin miscompares++; $display("FAIL dup_count: got %0d want 2", dup_count); end
    vectors++; if (gap_count !== 16'd0) begin miscompares++; $display("FAIL dup_gap: got %0d want 0", gap_count); end
    vectors++; if (err_pulses - ebase !== 2) begin miscompares++; $display("FAIL dup_pulses: got %0d want 2", err_pulses - ebase); end
    vectors++; if (got.size() - base !== 3) begin miscompares++; $display("FAIL dup_delivered: got %0d want 3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < got.size()) begin
        vectors++;
        if (got[base + i][95:64] !== out_seqs[i]) begin
          miscompares++; $display("FAIL dup_seq%0d: got %0d want %0d", i, got[base + i][95:64], out_seqs[i]);
        end
      end
    end
  endtask

  task automatic test_bad_hdr();
    int base, ebase;
    do_reset();
    order_ready = 1'b1;
    base = got.size();
    ebase = err_pulses;
    send(32'd2, 64'hC002, 32'h0);
    send(32'd3, 64'hDEAD, 32'h1);
    send(32'd3, 64'hC003, 32'h0);
    repeat (5) tick();
    vectors++; if (bad_hdr_count !== 16'd1) begin miscompares++; $display("FAIL bad_count: got %0d want 1", bad_hdr_count); end
    vectors++; if (gap_count !== 16'd0) begin miscompares++; $display("FAIL bad_gap: got %0d want 0", gap_count); end
    vectors++; if (dup_count !== 16'd0) begin miscompares++; $display("FAIL bad_dup: got %0d want 0", dup_count); end
    vectors++; if (err_pulses - ebase !== 1) begin miscompares++; $display("FAIL bad_pulses: got %0d want 1", err_pulses - ebase); end
    vectors++; if (got.size() - base !== 2) begin miscompares++; $display("FAIL bad_delivered: got %0d want 2", got.size() - base); end
    if (got.size() - base >= 2) begin
      vectors++; if (got[base] !== {32'd2, 64'hC002}) begin miscompares++; $display("FAIL bad_first: got %0h want %0h", got[base], {32'd2, 64'hC002}); end
      vectors++; if (got[base + 1] !== {32'd3, 64'hC003}) begin miscompares++; $display("FAIL bad_second: got %0h want %0h", got[base + 1], {32'd3, 64'hC003}); end
    end
  endtask

  task automatic test_overflow();
    int base, ebase;
    do_reset();
    order_ready = 1'b0;
    base = got.size();
    ebase = err_pulses;
    for (int i = 0; i < 3; i++) send(i, 64'h2000 + i, 32'h0);
    vectors++; if (order_valid !== 1'b1 || order_seq_out !== 32'd0) begin
      miscompares++; $display("FAIL ovf_head_early: got valid %0h seq %0d want 1/0", order_valid, order_seq_out);
    end
    for (int i = 3; i < 6; i++) send(i, 64'h2000 + i, 32'h0);
    repeat (3) tick();
    vectors++; if (overflow_count !== 16'd2) begin miscompares++; $display("FAIL ovf_count: got %0d want 2", overflow_count); end
    vectors++; if (order_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %0h want 1", order_valid); end
    vectors++; if ({order_seq_out, order_out} !== {32'd0, 64'h2000}) begin
      miscompares++; $display("FAIL ovf_head_stable: got %0h want %0h", {order_seq_out, order_out}, {32'd0, 64'h2000});
    end
    vectors++; if (err_pulses - ebase !== 0) begin miscompares++; $display("FAIL ovf_pulses: got %0d want 0", err_pulses - ebase); end
    order_ready = 1'b1;
    repeat (6) tick();
    vectors++; if (got.size() - base !== 4) begin miscompares++; $display("FAIL ovf_drained: got %0d want 4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < got.size()) begin
        vectors++;
        if (got[base + i] !== {i[31:0], 64'h2000 + i}) begin
          miscompares++; $display("FAIL ovf_entry%0d: got %0h want %0h", i, got[base + i], {i[31:0], 64'h2000 + i});
        end
      end
    end
    vectors++; if (order_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got %0h want 0", order_valid); end
    // Dropped frames still advanced tracking, so 6 is in order
    send(32'd6, 64'h2006, 32'h0);
    repeat (4) tick();
    vectors++; if (gap_count !== 16'd0) begin miscompares++; $display("FAIL ovf_tracking: got gap %0d want 0", gap_count); end
  endtask

  task automatic test_wrap_reset();
    int base;
    logic [31:0] seqs [3];
    seqs = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    do_reset();
    order_ready = 1'b1;
    base = got.size();
    for (int i = 0; i < 3; i++) send(seqs[i], 64'h3000 + i, 32'h0);
    send(32'd1, 64'hBAD, 32'h5);
    repeat (4) tick();
    vectors++; if (gap_count !== 16'd0 || dup_count !== 16'd0) begin
      miscompares++; $display("FAIL wrap_faults: got gap %0d dup %0d want 0/0", gap_count, dup_count);
    end
    vectors++; if (got.size() - base !== 3) begin miscompares++; $display("FAIL wrap_delivered: got %0d want 3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < got.size()) begin
        vectors++;
        if (got[base + i][95:64] !== seqs[i]) begin
          miscompares++; $display("FAIL wrap_seq%0d: got %0h want %0h", i, got[base + i][95:64], seqs[i]);
        end
      end
    end
    vectors++; if (bad_hdr_count !== 16'd1) begin miscompares++; $display("FAIL wrap_bad: got %0d want 1", bad_hdr_count); end
    order_ready = 1'b0;
    send(32'd1, 64'h3101, 32'h0);
    send(32'd2, 64'h3102, 32'h0);
    repeat (3) tick();
    vectors++; if (order_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_queued: got %0h want 1", order_valid); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++; if (order_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0h want 0", order_valid); end
    vectors++; if (bad_hdr_count !== 16'd0) begin miscompares++; $display("FAIL rst_counters: got %0d want 0", bad_hdr_count); end
    vectors++; if (seq_locked !== 1'b0) begin miscompares++; $display("FAIL rst_hunt: got %0h want 0", seq_locked); end
    tick();
    vectors++; if (order_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid_next: got %0h want 0", order_valid); end
    // Back in HUNT: an arbitrary sequence locks without counting a gap
    order_ready = 1'b1;
    base = got.size();
    send(32'd100, 64'h3164, 32'h0);
    repeat (4) tick();
    vectors++; if (gap_count !== 16'd0 || seq_locked !== 1'b1) begin
      miscompares++; $display("FAIL rst_relock: got gap %0d locked %0h want 0/1", gap_count, seq_locked);
    end
    vectors++; if (got.size() - base !== 1) begin miscompares++; $display("FAIL rst_relock_count: got %0d want 1", got.size() - base); end
  endtask

  initial begin
    reset = 1'b0;
    formatted_valid = 1'b0;
    formatted_order = '0;
    order_ready = 1'b0;
    tick();
    test_reset();
    test_in_order();
    test_gap();
    test_dup();
    test_bad_hdr();
    test_overflow();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
